// File: rtl/f1_light_sequencer.sv
// Start-lights control FSM: fills the lamp bar, hands ms ticks to the random-delay
// counter while holding, then times the player's reaction or flags a false start.
module f1_light_sequencer #(
    parameter int NUM_LIGHTS = 10,
    parameter int STEP_TICKS = 500,
    parameter int REACT_W    = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  time_out,
    output logic                  en_lfsr,
    output logic                  trigger,
    output logic [NUM_LIGHTS-1:0] ledr,
    output logic [REACT_W-1:0]    react_ms,
    output logic                  react_valid,
    output logic                  false_start,
    output logic [2:0]            o_state
);

    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [NUM_LIGHTS-1:0] ALL_ON    = {NUM_LIGHTS{1'b1}};
    localparam logic [REACT_W-1:0]    REACT_MAX = {REACT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_HOLD  = 3'd2,
        S_REACT = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_guard, w_guard_nxt;
    logic [STEP_W-1:0]     r_step, w_step_nxt;
    logic [REACT_W-1:0]    r_react_cnt, w_react_cnt_nxt;
    logic [NUM_LIGHTS-1:0] r_ledr, w_ledr_nxt;
    logic [REACT_W-1:0]    r_react_ms, w_react_ms_nxt;
    logic                  r_react_valid, w_react_valid_nxt;
    logic                  r_false_start, w_false_start_nxt;
    logic                  r_start_q, r_stop_q;
    logic                  w_start_edge, w_stop_edge;

    assign w_start_edge = start & ~r_start_q;
    assign w_stop_edge  = stop & ~r_stop_q;

    always_comb begin
        w_state_nxt       = r_state;
        w_step_nxt        = r_step;
        w_react_cnt_nxt   = r_react_cnt;
        w_ledr_nxt        = r_ledr;
        w_react_ms_nxt    = r_react_ms;
        w_react_valid_nxt = r_react_valid;
        w_false_start_nxt = r_false_start;
        case (r_state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (w_start_edge) begin
                    w_state_nxt       = S_FILL;
                    w_step_nxt        = '0;
                    w_ledr_nxt        = '0;
                    w_react_valid_nxt = 1'b0;
                    w_false_start_nxt = 1'b0;
                end
            end
            S_FILL: begin
                if (w_stop_edge) begin
                    w_state_nxt       = S_FAULT;
                    w_false_start_nxt = 1'b1;
                    w_react_valid_nxt = 1'b0;
                    w_ledr_nxt        = ALL_ON;
                end else if (tick) begin
                    if (r_step == STEP_LAST) begin
                        w_step_nxt = '0;
                        w_ledr_nxt = {r_ledr[NUM_LIGHTS-2:0], 1'b1};
                        // The lamp being shifted in now is the last one
                        if (&r_ledr[NUM_LIGHTS-2:0]) w_state_nxt = S_HOLD;
                    end else begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end
                end
            end
            S_HOLD: begin
                // Stop takes priority over a coincident time_out
                if (w_stop_edge) begin
                    w_state_nxt       = S_FAULT;
                    w_false_start_nxt = 1'b1;
                    w_react_valid_nxt = 1'b0;
                    w_ledr_nxt        = ALL_ON;
                end else if (time_out) begin
                    w_state_nxt     = S_REACT;
                    w_ledr_nxt      = '0;
                    w_react_cnt_nxt = '0;
                end
            end
            S_REACT: begin
                if (tick && (r_react_cnt != REACT_MAX)) w_react_cnt_nxt = r_react_cnt + REACT_W'(1);
                if (w_stop_edge) begin
                    w_state_nxt       = S_DONE;
                    w_react_ms_nxt    = r_react_cnt;
                    w_react_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Guard is high only on the first HOLD cycle so the delay counter can load N
    assign w_guard_nxt = (w_state_nxt == S_HOLD) && (r_state != S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_guard       <= 1'b0;
            r_step        <= '0;
            r_react_cnt   <= '0;
            r_ledr        <= '0;
            r_react_ms    <= '0;
            r_react_valid <= 1'b0;
            r_false_start <= 1'b0;
            r_start_q     <= 1'b1;
            r_stop_q      <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_guard       <= w_guard_nxt;
            r_step        <= w_step_nxt;
            r_react_cnt   <= w_react_cnt_nxt;
            r_ledr        <= w_ledr_nxt;
            r_react_ms    <= w_react_ms_nxt;
            r_react_valid <= w_react_valid_nxt;
            r_false_start <= w_false_start_nxt;
            r_start_q     <= start;
            r_stop_q      <= stop;
        end
    end

    assign en_lfsr     = (r_state != S_HOLD);
    assign trigger     = tick & (r_state == S_HOLD) & ~r_guard;
    assign ledr        = r_ledr;
    assign react_ms    = r_react_ms;
    assign react_valid = r_react_valid;
    assign false_start = r_false_start;
    assign o_state     = r_state;

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Directed bench for f1_light_sequencer: a REACT_W=14 instance plus a REACT_W=4
// instance on the same stimulus for the saturation case.
module tb_f1_light_sequencer;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_REACT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    logic        clk, rst_n, tick, start, stop, time_out;
    logic        en_lfsr, trigger, react_valid, false_start;
    logic [9:0]  ledr;
    logic [13:0] react_ms;
    logic [2:0]  o_state;
    logic        s_en_lfsr, s_trigger, s_react_valid, s_false_start;
    logic [9:0]  s_ledr;
    logic [3:0]  s_react_ms;
    logic [2:0]  s_state;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    f1_light_sequencer #(.NUM_LIGHTS(10), .STEP_TICKS(2), .REACT_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
        .time_out(time_out), .en_lfsr(en_lfsr), .trigger(trigger), .ledr(ledr),
        .react_ms(react_ms), .react_valid(react_valid), .false_start(false_start),
        .o_state(o_state)
    );

    f1_light_sequencer #(.NUM_LIGHTS(10), .STEP_TICKS(2), .REACT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
        .time_out(time_out), .en_lfsr(s_en_lfsr), .trigger(s_trigger), .ledr(s_ledr),
        .react_ms(s_react_ms), .react_valid(s_react_valid), .false_start(s_false_start),
        .o_state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        repeat (3) clk1();
    endtask

    task automatic press_start();
        start = 1'b1;
        clk1();
        start = 1'b0;
        clk1();
    endtask

    task automatic press_stop();
        stop = 1'b1;
        clk1();
        stop = 1'b0;
        clk1();
    endtask

    task automatic exp_push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s observed=%0h expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    task automatic exp_out(input logic [2:0] st, input logic [9:0] led, input logic en,
                           input logic vld, input logic fs);
        exp_push(32'(st));
        exp_push(32'(led));
        exp_push(32'(en));
        exp_push(32'(vld));
        exp_push(32'(fs));
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".state"}, 32'(o_state));
        chk({tag, ".ledr"}, 32'(ledr));
        chk({tag, ".en_lfsr"}, 32'(en_lfsr));
        chk({tag, ".react_valid"}, 32'(react_valid));
        chk({tag, ".false_start"}, 32'(false_start));
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; time_out = 1'b0;
        repeat (3) clk1();
        exp_out(ST_IDLE, 10'h000, 1'b1, 1'b0, 1'b0);
        exp_push(32'd0);
        exp_push(32'd0);
        chk_out("reset");
        chk("reset.trigger", 32'(trigger));
        chk("reset.react_ms", 32'(react_ms));
        rst_n = 1'b1;
        repeat (2) clk1();

        // Normal fill
        press_start();
        exp_out(ST_FILL, 10'h000, 1'b1, 1'b0, 1'b0);
        chk_out("start");
        repeat (2) do_tick();
        exp_out(ST_FILL, 10'h001, 1'b1, 1'b0, 1'b0);
        chk_out("lamp1");
        repeat (17) do_tick();
        exp_out(ST_FILL, 10'h1FF, 1'b1, 1'b0, 1'b0);
        chk_out("lamp9");
        tick = 1'b1;
        clk1();
        exp_out(ST_HOLD, 10'h3FF, 1'b0, 1'b0, 1'b0);
        chk_out("hold_entry");
        exp_push(32'd0);
        chk("trig_guard", 32'(trigger));
        clk1();
        exp_push(32'd1);
        chk("trig_tick", 32'(trigger));
        tick = 1'b0;
        #1;
        exp_push(32'd0);
        chk("trig_notick", 32'(trigger));
        clk1();
        press_start();
        exp_out(ST_HOLD, 10'h3FF, 1'b0, 1'b0, 1'b0);
        chk_out("start_in_hold");

        // Reaction of 37 ms
        time_out = 1'b1;
        clk1();
        time_out = 1'b0;
        exp_out(ST_REACT, 10'h000, 1'b1, 1'b0, 1'b0);
        chk_out("react_entry");
        repeat (37) do_tick();
        press_stop();
        exp_out(ST_DONE, 10'h000, 1'b1, 1'b1, 1'b0);
        exp_push(32'd37);
        exp_push(32'd15);
        chk_out("done37");
        chk("react37", 32'(react_ms));
        chk("sat_react37", 32'(s_react_ms));

        // Restart from DONE, then false start after 5 lamps
        press_start();
        exp_out(ST_FILL, 10'h000, 1'b1, 1'b0, 1'b0);
        exp_push(32'd37);
        chk_out("restart");
        chk("restart.react_ms", 32'(react_ms));
        repeat (2) do_tick();
        exp_out(ST_FILL, 10'h001, 1'b1, 1'b0, 1'b0);
        chk_out("refill1");
        repeat (8) do_tick();
        exp_out(ST_FILL, 10'h01F, 1'b1, 1'b0, 1'b0);
        chk_out("lamp5");
        press_stop();
        exp_out(ST_FAULT, 10'h3FF, 1'b1, 1'b0, 1'b1);
        exp_push(32'd37);
        chk_out("false_fill");
        chk("false_fill.react_ms", 32'(react_ms));

        // From FAULT: refill, then stop coincident with time_out
        press_start();
        exp_out(ST_FILL, 10'h000, 1'b1, 1'b0, 1'b0);
        chk_out("fault_restart");
        repeat (20) do_tick();
        exp_out(ST_HOLD, 10'h3FF, 1'b0, 1'b0, 1'b0);
        chk_out("hold2");
        stop = 1'b1; time_out = 1'b1;
        clk1();
        stop = 1'b0; time_out = 1'b0;
        exp_out(ST_FAULT, 10'h3FF, 1'b1, 1'b0, 1'b1);
        chk_out("stop_vs_timeout");

        // Saturation: 20 ticks on the 4-bit instance
        press_start();
        repeat (20) do_tick();
        time_out = 1'b1;
        clk1();
        time_out = 1'b0;
        repeat (20) do_tick();
        press_stop();
        exp_out(ST_DONE, 10'h000, 1'b1, 1'b1, 1'b0);
        exp_push(32'd20);
        exp_push(32'd15);
        exp_push(32'(ST_DONE));
        chk_out("done20");
        chk("react20", 32'(react_ms));
        chk("sat_react20", 32'(s_react_ms));
        chk("sat_state", 32'(s_state));

        // Reset mid-REACT with start held through reset
        press_start();
        repeat (20) do_tick();
        time_out = 1'b1;
        clk1();
        time_out = 1'b0;
        repeat (5) do_tick();
        exp_out(ST_REACT, 10'h000, 1'b1, 1'b0, 1'b0);
        chk_out("react_pre_rst");
        start = 1'b1;
        rst_n = 1'b0;
        #1;
        exp_out(ST_IDLE, 10'h000, 1'b1, 1'b0, 1'b0);
        exp_push(32'd0);
        chk_out("async_rst");
        chk("async_rst.react_ms", 32'(react_ms));
        repeat (2) clk1();
        rst_n = 1'b1;
        repeat (3) clk1();
        exp_out(ST_IDLE, 10'h000, 1'b1, 1'b0, 1'b0);
        chk_out("held_start");
        start = 1'b0;
        clk1();
        press_start();
        exp_out(ST_FILL, 10'h000, 1'b1, 1'b0, 1'b0);
        chk_out("repress_start");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f1_light_sequencer.md
Name: f1_light_sequencer

Overview:
- Control FSM for the Formula One start-lights game. It sits directly upstream of the random-delay counter.
- Fills the light bar one lamp at a time, then freezes the LFSR and feeds ms ticks to the delay counter as its trigger.
- On time_out it blanks the lights, measures the player's reaction time in ms, and flags false starts.

Parameters:
- NUM_LIGHTS, 10, number of lamps on ledr.
- STEP_TICKS, 500, tick strobes between successive lamps (500 ms at 1 kHz tick).
- REACT_W, 14, width of the reaction-time counter and result.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle 1 kHz strobe from the prescaler.
- start  input  1  debounced, synchronous start button (level).
- stop  input  1  debounced, synchronous reaction button (level).
- time_out  input  1  one-cycle pulse from the delay counter.
- en_lfsr  output  1  high lets the LFSR run; low freezes N and enables the delay counter.
- trigger  output  1  count strobe to the delay counter.
- ledr  output  NUM_LIGHTS  lamp drive, bit 0 is the first lamp.
- react_ms  output  REACT_W  last measured reaction time in ms.
- react_valid  output  1  react_ms holds a valid result.
- false_start  output  1  stop was pressed before the lights went out.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state IDLE; ledr 0; en_lfsr 1; trigger 0; react_ms 0; react_valid 0; false_start 0.
  - Step counter and reaction counter 0.
  - Previous-value registers for start and stop reset to 1, so a button held through reset produces no edge.
- Edge detection: start_edge = start & ~start_q and stop_edge = stop & ~stop_q, where start_q and stop_q are the previous-cycle values. Only edges act; held levels are ignored.
- en_lfsr is 0 only in HOLD; it is decoded from the state register.
- trigger = tick & (state==HOLD) & ~guard. It is combinational so the delay counter sees the tick on the same cycle.
- IDLE:
  - ledr 0.
  - start_edge -> FILL; clears the step counter, react_valid and false_start.
- FILL:
  - The step counter increments on each tick.
  - When it reaches STEP_TICKS-1 and tick is high: counter clears and ledr <= {ledr[NUM_LIGHTS-2:0],1'b1}.
  - The first lamp lights STEP_TICKS ticks after start_edge.
  - On the edge where ledr becomes all ones -> HOLD with guard set.
- HOLD:
  - ledr stays all ones; en_lfsr 0.
  - First cycle is the guard cycle: trigger forced 0 so the delay counter loads N. guard clears after one cycle.
  - time_out -> REACT: ledr <= 0, reaction counter cleared.
- REACT:
  - The reaction counter increments on each tick and saturates at 2^REACT_W-1 (no wrap).
  - stop_edge -> DONE: react_ms <= counter value before any same-cycle increment; react_valid <= 1.
- DONE:
  - Outputs hold.
  - start_edge -> FILL (same clears as from IDLE); react_ms keeps its old value until overwritten.
- False start: stop_edge in FILL or HOLD -> FAULT; false_start <= 1, react_valid <= 0, ledr <= all ones.
- Simultaneous stop_edge and time_out in HOLD: stop wins -> FAULT.
- FAULT: ledr all ones, en_lfsr 1. start_edge -> FILL and clears false_start.
- start_edge in FILL, HOLD or REACT is ignored.
- Reset mid-operation: immediate return to reset values. The delay counter is then reloaded by the next HOLD guard cycle.

Test Plan:
- Reset values: assert rst_n=0 mid-REACT -> outputs at reset values same cycle; after release, start held high gives no transition until released and re-pressed.
- Normal sequence (STEP_TICKS=2, NUM_LIGHTS=10, tick every 4 clks):
  - ledr 0x001 after 2 ticks, 0x3FF after 20 ticks; en_lfsr falls the same edge.
  - First HOLD cycle trigger=0 even with tick=1; afterwards trigger mirrors tick.
- Reaction measurement: time_out pulse, then 37 ticks, then stop edge -> ledr 0, react_ms=37, react_valid=1, state DONE.
- False start: stop edge after 5 lamps lit -> false_start=1, ledr=0x3FF, en_lfsr=1. Stop edge on the same cycle as time_out -> also FAULT.
- Saturation (REACT_W=4): 20 ticks in REACT, then stop -> react_ms=15.
- Restart from DONE: start edge -> react_valid=0, ledr refills from 0x001; react_ms keeps 37 until the next valid stop.
